// File: rtl/hmac_outer_feeder.sv
// Outer-hash sequencer for HMAC-SHA1: feeds (K xor opad) then the padded inner
// digest to the outer SHA-1 core and returns the resulting MAC on valid/ready.
module hmac_outer_feeder #(
  parameter logic [31:0] OPAD_WORD  = 32'h5c5c5c5c,
  parameter logic [31:0] MSG_BITLEN = 32'd672
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [159:0] inner_hash,
  input  logic [511:0] key_in,
  output logic [511:0] core_data,
  output logic         core_restart,
  output logic         core_start,
  input  logic         core_sha_ready,
  input  logic         core_valid,
  input  logic [159:0] core_hash,
  output logic [159:0] mac_out,
  output logic         mac_valid,
  input  logic         mac_ready
);

  typedef enum logic [2:0] {
    IDLE,
    KEY_SEND,
    KEY_WAIT,
    MSG_SEND,
    MSG_WAIT,
    OUT
  } state_t;

  state_t       r_state;
  logic [511:0] r_key;
  logic [159:0] r_hash;
  logic [511:0] r_core_data;
  logic [159:0] r_mac_out;
  logic         r_in_ready;
  logic         r_restart;
  logic         r_start;
  logic         r_mac_valid;

  logic [511:0] w_key_new_blk;
  logic [511:0] w_key_held_blk;
  logic [511:0] w_msg_blk;

  // Block builders: word gi of each 512-bit block sits at [32*gi+31:32*gi].
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi = gi + 1) begin : g_word
      assign w_key_new_blk[32*gi +: 32]  = key_in[32*gi +: 32] ^ OPAD_WORD;
      assign w_key_held_blk[32*gi +: 32] = r_key[32*gi +: 32] ^ OPAD_WORD;
      if (gi < 5) begin : g_hash
        assign w_msg_blk[32*gi +: 32] = r_hash[159-32*gi -: 32];
      end else if (gi == 5) begin : g_pad
        assign w_msg_blk[32*gi +: 32] = 32'h8000_0000;
      end else if (gi == 15) begin : g_len
        assign w_msg_blk[32*gi +: 32] = MSG_BITLEN;
      end else begin : g_zero
        assign w_msg_blk[32*gi +: 32] = 32'h0;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_key       <= '0;
      r_hash      <= '0;
      r_core_data <= '0;
      r_mac_out   <= '0;
      r_in_ready  <= 1'b1;
      r_restart   <= 1'b0;
      r_start     <= 1'b0;
      r_mac_valid <= 1'b0;
    end else begin
      r_restart <= 1'b0;
      r_start   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_key       <= key_in;
            r_hash      <= inner_hash;
            // Built from the live input so the block is valid on the entry edge.
            r_core_data <= w_key_new_blk;
            r_in_ready  <= 1'b0;
            r_state     <= KEY_SEND;
          end
        end
        KEY_SEND: begin
          r_core_data <= w_key_held_blk;
          if (core_sha_ready) begin
            r_restart <= 1'b1;
            r_state   <= KEY_WAIT;
          end
        end
        KEY_WAIT: begin
          // The digest here is only the intermediate chaining value.
          if (core_valid) begin
            r_core_data <= w_msg_blk;
            r_state     <= MSG_SEND;
          end
        end
        MSG_SEND: begin
          if (core_sha_ready) begin
            r_start <= 1'b1;
            r_state <= MSG_WAIT;
          end
        end
        MSG_WAIT: begin
          if (core_valid) begin
            r_mac_out   <= core_hash;
            r_key       <= '0;
            r_hash      <= '0;
            r_mac_valid <= 1'b1;
            r_state     <= OUT;
          end
        end
        OUT: begin
          if (mac_ready) begin
            r_mac_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready     = r_in_ready;
  assign core_data    = r_core_data;
  assign core_restart = r_restart;
  assign core_start   = r_start;
  assign mac_out      = r_mac_out;
  assign mac_valid    = r_mac_valid;

endmodule
